// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : run_ctrl_pkg
// Brief   : Shared types and defaults for the 3BC run sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package run_ctrl_pkg;

  localparam int          c_CYC_W   = 16;
  localparam logic [15:0] c_TIMEOUT = 16'd60000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  typedef struct packed {
    logic pcEn;
    logic pcLoad;
    logic ack;
    logic timeout;
  } runOut_t;

  // Moore output set for a state; registered alongside the state itself.
  function automatic runOut_t decodeOut(input state_t s);
    runOut_t o;
    o         = '0;
    o.pcEn    = (s == RUN);
    o.pcLoad  = (s == LOAD);
    o.ack     = (s == DONE) || (s == FAULT);
    o.timeout = (s == FAULT);
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/run_cycle_ctr.sv
`default_nettype none
// ============================================================================
// Module  : run_cycle_ctr
// Brief   : RUN cycle counter with clear, enable and watchdog terminal count.
// Revision: 1.0 - initial release
// ============================================================================
module run_cycle_ctr #(
  parameter int               CYC_W   = 16,
  parameter logic [CYC_W-1:0] TIMEOUT = CYC_W'(60000)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             En,
  output logic [CYC_W-1:0] Count,
  output logic             Tc
);

  logic [CYC_W-1:0] r_count;

  // Count enabled cycles; clear has priority over enable.
  always_ff @(posedge Clk) begin
    if (Reset || Clr) begin
      r_count <= '0;
    end else if (En) begin
      r_count <= r_count + CYC_W'(1);
    end
  end

  // Tc flags the cycle whose increment lands exactly on TIMEOUT.
  assign Tc    = (r_count == (TIMEOUT - CYC_W'(1)));
  assign Count = r_count;

endmodule
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : prog_run_ctrl
// Brief   : Run sequencer: Start/Ack handshake, PC base load, PC enable
//           gating, cycle counting and runaway-program watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module prog_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                        PC_W      = 10,
  parameter int                        CYC_W     = c_CYC_W,
  parameter int                        NUM_PROGS = 3,
  parameter logic [PC_W*NUM_PROGS-1:0] BASE_TBL  = '0,
  parameter logic [CYC_W-1:0]          TIMEOUT   = CYC_W'(c_TIMEOUT)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             HaltReq,
  output logic             PC_en,
  output logic             PC_load,
  output logic [PC_W-1:0]  PC_LoadVal,
  output logic [1:0]       ProgSel,
  output logic             Ack,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCt
);

  state_t     r_state;
  runOut_t    r_out;
  logic [1:0] r_progSel;
  logic       w_cntClr;
  logic       w_cntEn;
  logic       w_tc;

  // The abort cycle is not counted; a halt cycle is.
  assign w_cntClr = (r_state == LOAD);
  assign w_cntEn  = (r_state == RUN) && !Start;

  run_cycle_ctr #(
    .CYC_W   (CYC_W),
    .TIMEOUT (TIMEOUT)
  ) u_cycleCtr (
    .Clk   (Clk),
    .Reset (Reset),
    .Clr   (w_cntClr),
    .En    (w_cntEn),
    .Count (CycleCt),
    .Tc    (w_tc)
  );

  // Sequencer FSM; outputs are registered together with the next state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_progSel <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= ARMED;
            r_out   <= decodeOut(ARMED);
          end
        end
        ARMED: begin
          if (!Start) begin
            r_state <= LOAD;
            r_out   <= decodeOut(LOAD);
          end
        end
        LOAD: begin
          r_state <= RUN;
          r_out   <= decodeOut(RUN);
        end
        RUN: begin
          if (Start) begin
            r_state <= ARMED;
            r_out   <= decodeOut(ARMED);
          end else if (HaltReq) begin
            r_state <= DONE;
            r_out   <= decodeOut(DONE);
          end else if (w_tc) begin
            r_state <= FAULT;
            r_out   <= decodeOut(FAULT);
          end
        end
        DONE, FAULT: begin
          if (Start) begin
            r_state   <= ARMED;
            r_out     <= decodeOut(ARMED);
            r_progSel <= (r_progSel == 2'(NUM_PROGS - 1)) ? 2'd0 : r_progSel + 2'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign PC_en      = r_out.pcEn;
  assign PC_load    = r_out.pcLoad;
  assign Ack        = r_out.ack;
  assign Timeout    = r_out.timeout;
  assign ProgSel    = r_progSel;
  assign PC_LoadVal = BASE_TBL[int'(r_progSel)*PC_W +: PC_W];

endmodule
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_run_ctrl
// Brief   : Scoreboard bench for prog_run_ctrl with a run-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prog_run_ctrl;

  localparam int c_PC_W  = 10;
  localparam int c_CYC_W = 16;
  localparam int c_NP    = 3;
  localparam int c_TO    = 40;
  localparam logic [c_PC_W*c_NP-1:0] c_BASES = {10'd777, 10'd512, 10'd100};

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Start = 1'b0;
  logic              HaltReq = 1'b0;
  logic              PC_en;
  logic              PC_load;
  logic [c_PC_W-1:0] PC_LoadVal;
  logic [1:0]        ProgSel;
  logic              Ack;
  logic              Timeout;
  logic [c_CYC_W-1:0] CycleCt;

  prog_run_ctrl #(
    .PC_W      (c_PC_W),
    .CYC_W     (c_CYC_W),
    .NUM_PROGS (c_NP),
    .BASE_TBL  (c_BASES),
    .TIMEOUT   (16'(c_TO))
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .HaltReq    (HaltReq),
    .PC_en      (PC_en),
    .PC_load    (PC_load),
    .PC_LoadVal (PC_LoadVal),
    .ProgSel    (ProgSel),
    .Ack        (Ack),
    .Timeout    (Timeout),
    .CycleCt    (CycleCt)
  );

  always #5 Clk = ~Clk;

  // Run-level model: program start addresses and event queue.
  int baseOf [c_NP] = '{100, 512, 777};

  typedef struct {
    int kind;   // 0 = program load, 1 = run finished
    int sel;
    int val;
    int cyc;
    int to;
  } ev_t;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  mSel   = 0;
  bit  mDone  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a load or an Ack.
  logic prevAck  = 1'b0;
  bit   prevLoad = 0;
  always @(negedge Clk) begin
    ev_t e;
    if (prevLoad) check("pc_en_after_load", 32'(PC_en), 32'd1);
    if (PC_load === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_load", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("load_kind", 32'(e.kind), 32'd0);
        check("load_progsel", 32'(ProgSel), 32'(e.sel));
        check("load_val", 32'(PC_LoadVal), 32'(e.val));
      end
    end
    if (Ack === 1'b1 && prevAck !== 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("ack_kind", 32'(e.kind), 32'd1);
        check("ack_cyclect", 32'(CycleCt), 32'(e.cyc));
        check("ack_timeout", 32'(Timeout), 32'(e.to));
        check("ack_progsel", 32'(ProgSel), 32'(e.sel));
        check("ack_pc_en", 32'(PC_en), 32'd0);
      end
    end
    prevLoad = (PC_load === 1'b1);
    prevAck  = Ack;
  end

  // Setup phase: raise Start, idle in ARMED with stray halts, then launch.
  task automatic startPhase();
    bit wasDone;
    ev_t e;
    wasDone = mDone;
    Start   = 1'b1;
    @(negedge Clk);
    if (wasDone) begin
      check("ack_drop", 32'(Ack), 32'd0);
      check("timeout_drop", 32'(Timeout), 32'd0);
      mSel  = (mSel + 1) % c_NP;
      mDone = 0;
    end
    repeat ($urandom_range(0, 4)) begin
      HaltReq = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    HaltReq = 1'b0;
    Start   = 1'b0;
    e = '{kind: 0, sel: mSel, val: baseOf[mSel], cyc: 0, to: 0};
    q.push_back(e);
  endtask

  task automatic finishPhase();
    repeat ($urandom_range(0, 3)) begin
      HaltReq = 1'($urandom_range(0, 1));
      @(negedge Clk);
    end
    HaltReq = 1'b0;
  endtask

  // Halt on RUN cycle k (1-based).
  task automatic doHalt(input int k);
    ev_t e;
    startPhase();
    repeat (k + 1) @(negedge Clk);
    HaltReq = 1'b1;
    e = '{kind: 1, sel: mSel, val: 0, cyc: k, to: 0};
    q.push_back(e);
    @(negedge Clk);
    HaltReq = 1'b0;
    mDone   = 1;
    finishPhase();
  endtask

  task automatic doTimeout();
    ev_t e;
    startPhase();
    e = '{kind: 1, sel: mSel, val: 0, cyc: c_TO, to: 1};
    q.push_back(e);
    repeat (c_TO + 3) @(negedge Clk);
    mDone = 1;
    finishPhase();
  endtask

  // Abort with Start on RUN cycle k, optionally with a simultaneous halt.
  task automatic doAbort(input int k, input bit h);
    startPhase();
    repeat (k + 1) @(negedge Clk);
    Start   = 1'b1;
    HaltReq = h;
    @(negedge Clk);
    HaltReq = 1'b0;
    check("abort_ack", 32'(Ack), 32'd0);
    check("abort_pc_en", 32'(PC_en), 32'd0);
    check("abort_cyclect", 32'(CycleCt), 32'(k - 1));
    check("abort_progsel", 32'(ProgSel), 32'(mSel));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_pc_en"}, 32'(PC_en), 32'd0);
    check({tag, "_pc_load"}, 32'(PC_load), 32'd0);
    check({tag, "_ack"}, 32'(Ack), 32'd0);
    check({tag, "_timeout"}, 32'(Timeout), 32'd0);
    check({tag, "_progsel"}, 32'(ProgSel), 32'd0);
    check({tag, "_cyclect"}, 32'(CycleCt), 32'd0);
  endtask

  initial begin
    int m;
    int nxt;
    repeat (2) @(negedge Clk);
    checkAllZero("reset");
    Reset = 1'b0;
    @(negedge Clk);

    doHalt(37);             // program 0, 37 RUN cycles
    doTimeout();            // program 1, watchdog
    doHalt(c_TO);           // program 2, halt on the last legal cycle
    doHalt(1);              // wraps to program 0, single-cycle run
    doAbort(5, 1'b1);       // Start beats HaltReq
    doHalt(3);              // same program after abort

    for (int i = 0; i < 20; i++) begin
      m = $urandom_range(0, 9);
      if (m <= 5)      doHalt($urandom_range(1, c_TO));
      else if (m <= 7) doTimeout();
      else             doAbort($urandom_range(1, c_TO - 1), 1'($urandom_range(0, 1)));
    end

    // Reach program 2, then reset in the middle of its run.
    nxt = mDone ? (mSel + 1) % c_NP : mSel;
    while (nxt != 2) begin
      doHalt($urandom_range(1, 10));
      nxt = (mSel + 1) % c_NP;
    end
    startPhase();
    repeat (6) @(negedge Clk);
    check("pre_reset_progsel", 32'(ProgSel), 32'd2);
    check("pre_reset_pc_en", 32'(PC_en), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    checkAllZero("midrun_reset");
    Reset = 1'b0;
    mSel  = 0;
    mDone = 0;
    repeat (2) @(negedge Clk);
    doHalt(5);              // must run program 0 again

    repeat (4) @(negedge Clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
